// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
// MMIO window on the data-memory port. A 16-word block at address[11:4]==BASE
// is served with syncram-style timing (1-edge read latency, read-before-write).
// Registers: TXDATA (byte FIFO push), STATUS, CYCLES (free-running counter),
// SCRATCH. The FIFO is drained by a ready/valid byte consumer.
module dmem_mmio_responder #(
    parameter logic [7:0] BASE  = 8'hFF,
    parameter int         DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        sel,
    output logic [31:0] q,
    output logic        q_sel,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    // Pointer width is log2(DEPTH); the count needs one more bit to reach DEPTH.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Register offsets inside the window.
    localparam logic [3:0] A_TXDATA  = 4'h0;
    localparam logic [3:0] A_STATUS  = 4'h1;
    localparam logic [3:0] A_CYCLES  = 4'h2;
    localparam logic [3:0] A_SCRATCH = 4'h3;

    // Catch illegal FIFO sizes at elaboration rather than building a broken ring.
    if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_mmio_responder: DEPTH must be a power of two in 2..128");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_cycles;
    logic [31:0]   r_scratch;
    logic [31:0]   r_q;
    logic          r_q_sel;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          w_sel;
    logic          w_wr;
    logic [3:0]    w_off;
    logic          w_wr_tx;
    logic          w_wr_status;
    logic          w_wr_cycles;
    logic          w_wr_scratch;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [7:0]    w_count8;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign w_sel        = (address[11:4] == BASE);
    assign w_off        = address[3:0];
    assign w_wr         = wren && w_sel;
    assign w_wr_tx      = w_wr && (w_off == A_TXDATA);
    assign w_wr_status  = w_wr && (w_off == A_STATUS);
    assign w_wr_cycles  = w_wr && (w_off == A_CYCLES);
    assign w_wr_scratch = w_wr && (w_off == A_SCRATCH);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = !w_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge;
    // the new byte lands in the slot being vacated.
    assign w_push_ok = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_set = w_wr_tx && w_full && !w_pop;
    assign w_ovf_clr = w_wr_status && data[2];

    assign w_count8 = 8'(r_count);
    assign w_status = {16'b0, w_count8, 5'b0, r_overflow, w_full, w_empty};

    // Read mux over pre-edge register values; unmapped offsets read as zero.
    always_comb begin
        w_rdata = 32'h0;
        if (w_sel) begin
            case (w_off)
                A_STATUS:  w_rdata = w_status;
                A_CYCLES:  w_rdata = r_cycles;
                A_SCRATCH: w_rdata = r_scratch;
                default:   w_rdata = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Registered read port: q/q_sel follow address by one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q     <= 32'h0;
            r_q_sel <= 1'b0;
        end else begin
            r_q     <= w_rdata;
            r_q_sel <= w_sel;
        end
    end

    // FIFO storage; contents need no reset since validity comes from r_count.
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= data[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a new overflow beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_overflow <= 1'b0;
        else if (w_ovf_set) r_overflow <= 1'b1;
        else if (w_ovf_clr) r_overflow <= 1'b0;
    end

    // Free-running cycle counter; a write loads instead of incrementing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            r_cycles <= 32'h0;
        else if (w_wr_cycles) r_cycles <= data;
        else                  r_cycles <= r_cycles + 32'd1;
    end

    // Scratch register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)             r_scratch <= 32'h0;
        else if (w_wr_scratch) r_scratch <= data;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sel       = w_sel;
    assign q         = r_q;
    assign q_sel     = r_q_sel;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder (BASE=8'hFF, DEPTH=8).
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [11:0] address;
    logic [31:0] data;
    logic        wren;
    logic        sel;
    logic [31:0] q;
    logic        q_sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    dmem_mmio_responder #(.BASE(8'hFF), .DEPTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .data     (data),
        .wren     (wren),
        .sel      (sel),
        .q        (q),
        .q_sel    (q_sel),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address = a; data = d; wren = 1'b1;
        cyc();
        wren = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a);
        address = a; wren = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; address = 12'h000; data = 32'h0; wren = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_q got %h exp %h", q, 32'h0); end
        checks++; if (q_sel !== 1'b0) begin errors++; $display("FAIL rst_q_sel got %b exp 0", q_sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        cyc(); cyc();
        reset = 1'b0;
        rd(12'hFF2);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL cycles_first got %h exp %h", q, 32'h0); end
        rd(12'hFF2);
        checks++; if (q !== 32'h1) begin errors++; $display("FAIL cycles_second got %h exp %h", q, 32'h1); end
        rd(12'hFF3);
        checks++; if (q !== 32'h0 || q_sel !== 1'b1) begin errors++; $display("FAIL rd_scratch_rst got %h/%b exp 0/1", q, q_sel); end
        rd(12'hFF1);
        checks++; if (q !== 32'h1 || q_sel !== 1'b1) begin errors++; $display("FAIL rd_status_rst got %h/%b exp 1/1", q, q_sel); end
        rd(12'h100);
        checks++; if (q !== 32'h0 || q_sel !== 1'b0) begin errors++; $display("FAIL rd_outside got %h/%b exp 0/0", q, q_sel); end
    endtask

    task automatic test_sel();
        address = 12'hFF5; #1;
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_in got %b exp 1", sel); end
        address = 12'hFE5; #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_out got %b exp 0", sel); end
        wr(12'hFF8, 32'h12345678);
        rd(12'hFF8);
        checks++; if (q !== 32'h0 || q_sel !== 1'b1) begin errors++; $display("FAIL rd_unmapped got %h/%b exp 0/1", q, q_sel); end
    endtask

    task automatic test_scratch();
        wr(12'hFF3, 32'hDEADBEEF);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL scratch_rbw got %h exp %h", q, 32'h0); end
        rd(12'hFF3);
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch_rd got %h exp %h", q, 32'hDEADBEEF); end
        // Same offset outside the window must not reach SCRATCH.
        wr(12'h0F3, 32'h12345678);
        rd(12'hFF3);
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch_nosel got %h exp %h", q, 32'hDEADBEEF); end
        rd(12'hFF0);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL txdata_rd got %h exp %h", q, 32'h0); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(12'hFF0, 32'h10 + i);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin errors++; $display("FAIL first_push got %b/%h exp 1/10", out_valid, out_data); end
            end
        end
        rd(12'hFF1);
        checks++; if (q !== 32'h00000806) begin errors++; $display("FAIL status_ovf got %h exp %h", q, 32'h00000806); end
        address = 12'h000; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, out_valid, out_data, 8'(8'h10 + i)); end
            cyc();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
        rd(12'hFF1);
        checks++; if (q !== 32'h00000005) begin errors++; $display("FAIL status_sticky got %h exp %h", q, 32'h00000005); end
        wr(12'hFF1, 32'h4);
        rd(12'hFF1);
        checks++; if (q !== 32'h00000001) begin errors++; $display("FAIL status_clr got %h exp %h", q, 32'h00000001); end
    endtask

    task automatic test_full_pop_push();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(12'hFF0, 32'h20 + i);
        out_ready = 1'b1;
        wr(12'hFF0, 32'hAA);
        out_ready = 1'b0;
        rd(12'hFF1);
        checks++; if (q !== 32'h00000802) begin errors++; $display("FAIL status_fullpp got %h exp %h", q, 32'h00000802); end
        address = 12'h000; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'hAA : 8'(8'h21 + i);
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL fullpp_%0d got %b/%h exp 1/%h", i, out_valid, out_data, exp); end
            cyc();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int j = 0; j < 8; j++) wr(12'hFF0, 32'h30 + r * 8 + j);
            address = 12'h000; out_ready = 1'b1;
            for (int j = 0; j < 8; j++) begin
                checks++; if (out_data !== 8'(8'h30 + r * 8 + j)) begin errors++; $display("FAIL wrap_%0d_%0d got %h exp %h", r, j, out_data, 8'(8'h30 + r * 8 + j)); end
                cyc();
            end
        end
        out_ready = 1'b0;
        rd(12'hFF1);
        checks++; if (q !== 32'h00000001) begin errors++; $display("FAIL wrap_status got %h exp %h", q, 32'h00000001); end
    endtask

    task automatic test_cycles();
        wr(12'hFF2, 32'hFFFFFFFE);
        rd(12'hFF2);
        checks++; if (q !== 32'hFFFFFFFE) begin errors++; $display("FAIL cycles_ld got %h exp %h", q, 32'hFFFFFFFE); end
        rd(12'hFF2);
        checks++; if (q !== 32'hFFFFFFFF) begin errors++; $display("FAIL cycles_max got %h exp %h", q, 32'hFFFFFFFF); end
        rd(12'hFF2);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL cycles_wrap got %h exp %h", q, 32'h0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(12'hFF0, 32'h40 + i);
        address = 12'hFF1; out_ready = 1'b1;
        cyc();
        checks++; if (q !== 32'h00000400 || out_data !== 8'h41) begin errors++; $display("FAIL mid_pre got %h/%h exp 400/41", q, out_data); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || q !== 32'h0 || q_sel !== 1'b0) begin errors++; $display("FAIL mid_async got %b/%h/%b exp 0/0/0", out_valid, q, q_sel); end
        cyc();
        reset = 1'b0; out_ready = 1'b0;
        rd(12'hFF1);
        checks++; if (q !== 32'h00000001) begin errors++; $display("FAIL mid_post_status got %h exp %h", q, 32'h00000001); end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_scratch();
        test_overflow();
        test_full_pop_push();
        test_wrap();
        test_cycles();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
